// File: rtl/logic_sweep_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// logic_sweep_engine: walks every input vector of N_OUT LUT-defined functions,
// streams vector+results over valid/ready and counts ones per output.
// Revision: 1.0
// ============================================================================
module logic_sweep_engine #(
   parameter int N_IN     = 4,
   parameter int N_OUT    = 3,
   parameter int STEP_GAP = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [N_OUT*(2**N_IN)-1:0]    lut_cfg,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_IN-1:0]               out_vec,
   output logic [N_OUT-1:0]              out_res,
   output logic [N_OUT*(N_IN+1)-1:0]     ones_cnt,
   output logic                          busy,
   output logic                          done
);

   localparam int SIZE = 2**N_IN;
   localparam int CW   = N_IN + 1;
   localparam int GW   = 4;
   localparam logic [CW-1:0] LAST     = CW'(SIZE - 1);
   localparam logic [GW-1:0] GAP_LAST = (STEP_GAP > 0) ? GW'(STEP_GAP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [N_OUT*SIZE-1:0]  lut;
   logic [CW-1:0]          count;
   logic [GW-1:0]          gap_cnt;
   logic                   accept;
   logic                   launch;

   assign accept    = (state == S_RUN) && out_ready;
   assign launch    = (state == S_IDLE) && start;
   assign out_valid = (state == S_RUN);
   assign busy      = (state == S_RUN) || (state == S_GAP);
   assign done      = (state == S_DONE);
   assign out_vec   = count[N_IN-1:0];

   // Results are looked up straight from the latched tables so they follow
   // out_vec and stay stable while the beat is stalled.
   generate
      for (genvar j = 0; j < N_OUT; j++) begin : g_res
         logic [SIZE-1:0] tbl;
         assign tbl        = lut[j*SIZE +: SIZE];
         assign out_res[j] = tbl[out_vec];
      end
   endgenerate

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = S_RUN;
         S_RUN: begin
            // Abort wins over completion: an aborted sweep never reports done.
            if (abort)
               state_nx = S_IDLE;
            else if (accept) begin
               if (count == LAST)
                  state_nx = S_DONE;
               else if (STEP_GAP > 0)
                  state_nx = S_GAP;
               else
                  state_nx = S_RUN;
            end
         end
         S_GAP: begin
            if (abort)
               state_nx = S_IDLE;
            else if (gap_cnt == GAP_LAST)
               state_nx = S_RUN;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         lut      <= '0;
         count    <= '0;
         gap_cnt  <= '0;
         ones_cnt <= '0;
      end else begin
         state <= state_nx;
         if (launch) begin
            lut      <= lut_cfg;
            count    <= '0;
            ones_cnt <= '0;
         end
         if (accept) begin
            if (count != LAST)
               count <= count + CW'(1);
            for (int j = 0; j < N_OUT; j++)
               ones_cnt[j*CW +: CW] <= ones_cnt[j*CW +: CW] + CW'(out_res[j]);
         end
         if (state == S_GAP)
            gap_cnt <= gap_cnt + GW'(1);
         else
            gap_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_logic_sweep_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_logic_sweep_engine: scoreboard bench for two builds (STEP_GAP 0 and 2)
// sharing one stimulus stream; sel chooses which build is being checked.
// Revision: 1.0
// ============================================================================
module tb_logic_sweep_engine;

   localparam int NI = 4;
   localparam int NO = 3;
   localparam int SZ = 16;
   localparam int CW = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic [NO*SZ-1:0]  lut_cfg = '0;

   logic              v0, b0, d0, v2, b2, d2;
   logic [NI-1:0]     vec0, vec2;
   logic [NO-1:0]     res0, res2;
   logic [NO*CW-1:0]  cnt0, cnt2;

   logic              m_valid, m_busy, m_done;
   logic [NI-1:0]     m_vec;
   logic [NO-1:0]     m_res;
   logic [NO*CW-1:0]  m_cnt;
   int                sel = 0;

   always #5 clk = ~clk;

   logic_sweep_engine #(.N_IN(NI), .N_OUT(NO), .STEP_GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lut_cfg(lut_cfg),
      .out_valid(v0), .out_ready(out_ready), .out_vec(vec0), .out_res(res0),
      .ones_cnt(cnt0), .busy(b0), .done(d0));

   logic_sweep_engine #(.N_IN(NI), .N_OUT(NO), .STEP_GAP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lut_cfg(lut_cfg),
      .out_valid(v2), .out_ready(out_ready), .out_vec(vec2), .out_res(res2),
      .ones_cnt(cnt2), .busy(b2), .done(d2));

   always_comb begin
      m_valid = (sel == 1) ? v2   : v0;
      m_busy  = (sel == 1) ? b2   : b0;
      m_done  = (sel == 1) ? d2   : d0;
      m_vec   = (sel == 1) ? vec2 : vec0;
      m_res   = (sel == 1) ? res2 : res0;
      m_cnt   = (sel == 1) ? cnt2 : cnt0;
   end

   typedef struct {
      logic [NI-1:0] vec;
      logic [NO-1:0] res;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         e;
   int            exp_ones[NO];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            last_acc_cyc = -1;
   logic          stall_prev = 1'b0;
   logic [NI-1:0] vec_prev = '0;
   logic [NO-1:0] res_prev = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   // Monitor: consumes the expected queue on every accepted beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_vec", 64'(m_vec), 64'(vec_prev));
            chk("hold_res", 64'(m_res), 64'(res_prev));
         end
         if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got vec %0d expected no beat", m_vec);
            end else begin
               e = exp_q.pop_front();
               chk("beat_vec", 64'(m_vec), 64'(e.vec));
               chk("beat_res", 64'(m_res), 64'(e.res));
               for (int j = 0; j < NO; j++) begin
                  chk("ones_running", 64'(m_cnt[j*CW +: CW]), 64'(exp_ones[j]));
                  exp_ones[j] += int'(e.res[j]);
               end
            end
            last_acc_cyc = cyc;
         end
         stall_prev = m_valid && !out_ready && !abort;
         vec_prev   = m_vec;
         res_prev   = m_res;
         if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   function automatic logic [NO*SZ-1:0] formula_lut();
      logic [NO*SZ-1:0] c;
      logic [3:0]       b;
      logic             x1, x2, x3, x4, g, h;
      c = '0;
      for (int v = 0; v < SZ; v++) begin
         b  = 4'(v);
         x1 = b[0]; x2 = b[1]; x3 = b[2]; x4 = b[3];
         g  = (x1 & x3) | (x2 & x4);
         h  = (x1 | ~x3) & (~x2 | x4);
         c[v]        = g;
         c[SZ + v]   = h;
         c[2*SZ + v] = g | h;
      end
      return c;
   endfunction

   function automatic logic [NO*SZ-1:0] rand_lut();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[NO*SZ-1:0];
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_busy"},  64'(m_busy),  64'd0);
      chk({tag, "_done"},  64'(m_done),  64'd0);
      chk({tag, "_vec"},   64'(m_vec),   64'd0);
      chk({tag, "_res"},   64'(m_res),   64'd0);
      chk({tag, "_cnt"},   64'(m_cnt),   64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // rmode: 0 ready high, 1 random ready, 2 ready low for 3 cycles at vector 5.
   task automatic run_sweep(input logic [NO*SZ-1:0] cfg, input int rmode,
                            input bit poke_start, input bit do_abort, input int exp_lat);
      int  t0;
      int  hold = 0;
      int  d_before;
      bit  poked = 0;
      bit  aborted = 0;
      beat_t b;
      exp_q.delete();
      for (int j = 0; j < NO; j++) exp_ones[j] = 0;
      for (int v = 0; v < SZ; v++) begin
         b.vec = NI'(v);
         for (int j = 0; j < NO; j++) b.res[j] = cfg[j*SZ + v];
         exp_q.push_back(b);
      end
      d_before = done_cnt;
      @(posedge clk); #1;
      lut_cfg = cfg; start = 1'b1; out_ready = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      lut_cfg = rand_lut();
      for (int k = 0; k < 400 && done_cnt == d_before && !aborted; k++) begin
         case (rmode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (m_valid && m_vec == 4'd5 && hold < 3) begin
                  out_ready = 1'b0;
                  hold++;
               end else
                  out_ready = 1'b1;
            end
            default: out_ready = 1'b1;
         endcase
         if (poke_start && !poked && m_valid && m_vec == 4'd8) begin
            start = 1'b1;
            lut_cfg = rand_lut();
            poked = 1;
         end
         if (do_abort && m_valid && m_vec == 4'd8) begin
            abort = 1'b1;
            out_ready = 1'b0;
            aborted = 1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
      end
      @(negedge clk);
      if (aborted) begin
         chk("abort_valid", 64'(m_valid), 64'd0);
         chk("abort_busy", 64'(m_busy), 64'd0);
         for (int j = 0; j < NO; j++)
            chk("abort_ones", 64'(m_cnt[j*CW +: CW]), 64'(exp_ones[j]));
         repeat (4) @(negedge clk);
         chk("abort_no_done", 64'(done_cnt), 64'(d_before));
         exp_q.delete();
      end else if (done_cnt == d_before) begin
         total++;
         bad++;
         $display("FAIL sweep_timeout: got no done expected done within 400 cycles");
      end else begin
         if (exp_lat > 0) chk("done_latency", 64'(done_cyc - t0), 64'(exp_lat));
         chk("done_after_last_beat", 64'(done_cyc - last_acc_cyc), 64'd1);
         chk("queue_drained", 64'(exp_q.size()), 64'd0);
         chk("done_pulse_width", 64'(m_done), 64'd0);
         chk("idle_after_done", 64'(m_busy), 64'd0);
         for (int j = 0; j < NO; j++)
            chk("final_ones", 64'(m_cnt[j*CW +: CW]), 64'(exp_ones[j]));
      end
      out_ready = 1'b0;
   endtask

   task automatic reset_mid_gap();
      int  d_before;
      bit  hit = 0;
      exp_q.delete();
      for (int j = 0; j < NO; j++) exp_ones[j] = 0;
      for (int v = 0; v < SZ; v++) begin
         e.vec = NI'(v);
         for (int j = 0; j < NO; j++) e.res[j] = lut_cfg[j*SZ + v];
         exp_q.push_back(e);
      end
      d_before = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         if (m_busy && !m_valid && m_vec >= 4'd3) hit = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("gap_reached", 64'(hit), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_mid_gap");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_no_done", 64'(done_cnt), 64'(d_before));
      chk("rst_stays_idle", 64'(m_busy), 64'd0);
      exp_q.delete();
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel = 0; #1 check_all_zero("reset_gap0");
      sel = 1; #1 check_all_zero("reset_gap2");
      sel = 0;
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b0;
      rst_n = 1'b1;

      run_sweep(formula_lut(), 0, 0, 0, 17);
      run_sweep(formula_lut(), 2, 0, 0, 0);
      run_sweep(formula_lut(), 0, 1, 0, 17);
      run_sweep(formula_lut(), 0, 0, 1, 0);
      repeat (3) run_sweep(rand_lut(), 1, 0, 0, 0);

      do_reset();
      sel = 1;
      run_sweep(formula_lut(), 0, 0, 0, 47);
      repeat (2) run_sweep(rand_lut(), 1, 0, 0, 0);
      lut_cfg = formula_lut();
      reset_mid_gap();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before 2ms");
      $fatal(1);
   end

endmodule
`default_nettype wire
